// File: rtl/prt_scaler_coef_ram.sv
// prt_scaler_coef_ram: double-banked scaler coefficient table, host writes the shadow bank, swap on frame boundary.
// Optional PRT_SCALER_COEF_CLR_EN compiles in a clear FSM that zeroes both banks after every reset.
module prt_scaler_coef_ram #(
    parameter int P_MODE  = 2,
    parameter int P_IDX   = 7,
    parameter int P_DAT   = 8,
    parameter int P_PORTS = 2
) (
    input  logic                              CLK_IN,
    input  logic                              RST_IN,
    input  logic                              WR_EN_IN,
    input  logic [P_MODE+P_IDX-1:0]           WR_SEL_IN,
    input  logic [P_DAT-1:0]                  WR_DAT_IN,
    input  logic                              SWAP_REQ_IN,
    input  logic                              VS_IN,
    input  logic [P_PORTS*(P_MODE+P_IDX)-1:0] RD_SEL_IN,
    output logic [P_PORTS*P_DAT-1:0]          RD_DAT_OUT,
    output logic                              BANK_OUT,
    output logic                              SWAP_PEND_OUT,
    output logic                              BUSY_OUT
);
    localparam int AW = P_MODE + P_IDX;
    localparam int D  = 1 << AW;

    logic [P_DAT-1:0] mem0_q [D];
    logic [P_DAT-1:0] mem1_q [D];
    logic bank_q, bank_d, pend_q, pend_d, busy, swap;
    logic [P_PORTS-1:0][AW-1:0] rd_sel;
    logic [P_PORTS-1:0][P_DAT-1:0] rd1_d, rd1_q, rd2_q;

    assign rd_sel = RD_SEL_IN;

`ifdef PRT_SCALER_COEF_CLR_EN
    typedef enum logic {S_IDLE, S_CLR} state_t;
    state_t state_q;
    logic [AW-1:0] cnt_q;

    always_ff @(posedge CLK_IN) begin
        if (!RST_IN) begin
            state_q <= S_CLR;
            cnt_q   <= '0;
        end else if (state_q == S_CLR) begin
            cnt_q <= cnt_q + AW'(1);
            if (cnt_q == AW'(D - 1))
                state_q <= S_IDLE;
        end
    end

    assign busy = (state_q == S_CLR);
`else
    assign busy = 1'b0;
`endif

    assign swap = VS_IN && (pend_q || SWAP_REQ_IN) && !busy;

    always_comb begin
        bank_d = swap ? ~bank_q : bank_q;
        pend_d = !busy && !swap && (pend_q || SWAP_REQ_IN);
        for (int p = 0; p < P_PORTS; p++)
            rd1_d[p] = busy ? '0 : (bank_q ? mem1_q[rd_sel[p]] : mem0_q[rd_sel[p]]);
    end

    // Table storage is never reset; only the clear sequence zeroes it.
    always_ff @(posedge CLK_IN) begin
`ifdef PRT_SCALER_COEF_CLR_EN
        if (busy && RST_IN) begin
            mem0_q[cnt_q] <= '0;
            mem1_q[cnt_q] <= '0;
        end
`endif
        if (WR_EN_IN && !busy) begin
            if (bank_q)
                mem0_q[WR_SEL_IN] <= WR_DAT_IN;
            else
                mem1_q[WR_SEL_IN] <= WR_DAT_IN;
        end
    end

    always_ff @(posedge CLK_IN) begin
        if (!RST_IN) begin
            bank_q <= 1'b0;
            pend_q <= 1'b0;
            rd1_q  <= '0;
            rd2_q  <= '0;
        end else begin
            bank_q <= bank_d;
            pend_q <= pend_d;
            rd1_q  <= rd1_d;
            rd2_q  <= busy ? '0 : rd1_q;
        end
    end

    assign RD_DAT_OUT    = busy ? '0 : rd2_q;
    assign BANK_OUT      = bank_q;
    assign SWAP_PEND_OUT = pend_q;
    assign BUSY_OUT      = busy;
endmodule

// File: doc/prt_scaler_coef_ram.md
PRT_SCALER_COEF_RAM -- requirements
Module: prt_scaler_coef_ram

Interface
REQ-001 Parameter P_MODE, default 2, mode-select width.
REQ-002 Parameter P_IDX, default 7, coefficient-index width; table depth per bank D = 2^(P_MODE+P_IDX).
REQ-003 Parameter P_DAT, default 8, coefficient width.
REQ-004 Parameter P_PORTS, default 2, number of independent read ports.
REQ-005 CLK_IN  in  1  single clock.
REQ-006 RST_IN  in  1  reset, synchronous, active-low.
REQ-007 WR_EN_IN  in  1  host write strobe to the shadow bank.
REQ-008 WR_SEL_IN  in  P_MODE+P_IDX  write address {mode, index}.
REQ-009 WR_DAT_IN  in  P_DAT  write data.
REQ-010 SWAP_REQ_IN  in  1  single-cycle pulse; requests an active/shadow swap.
REQ-011 VS_IN  in  1  single-cycle frame-boundary pulse.
REQ-012 RD_SEL_IN  in  P_PORTS*(P_MODE+P_IDX)  read addresses; port p in slice p.
REQ-013 RD_DAT_OUT  out  P_PORTS*P_DAT  read data; port p in slice p.
REQ-014 BANK_OUT  out  1  current active bank.
REQ-015 SWAP_PEND_OUT  out  1  swap requested, not yet applied.
REQ-016 BUSY_OUT  out  1  clear sequence in progress.

Function
REQ-017 The block SHALL hold two banks of D x P_DAT entries; reads always use the active bank (BANK_OUT); writes always target the shadow bank (~BANK_OUT).
REQ-018 Read latency: RD_SEL_IN sampled in cycle N, the corresponding RD_DAT_OUT is valid in cycle N+2; the bank used is BANK_OUT as sampled in cycle N.
REQ-019 All P_PORTS ports SHALL be read every cycle without stall, with no arbitration between them.
REQ-020 A write in cycle N SHALL be visible to a read whose RD_SEL_IN is sampled in cycle N+1 or later, provided that bank is active by then.
REQ-021 SWAP_REQ_IN SHALL set SWAP_PEND_OUT in the next cycle; repeated requests while pending SHALL have no additional effect.
REQ-022 When VS_IN=1 and (SWAP_PEND_OUT=1 or SWAP_REQ_IN=1), BANK_OUT SHALL toggle and SWAP_PEND_OUT SHALL be 0 in the next cycle.
REQ-023 VS_IN without a pending or simultaneous request SHALL leave BANK_OUT unchanged.
REQ-024 A write in the same cycle as a swap SHALL go to the bank that was shadow before the swap, i.e. the newly active bank.
REQ-025 Out-of-range values do not exist; every WR_SEL_IN/RD_SEL_IN value addresses a location (full decode, no wrap logic).
REQ-026 Clear FSM states: IDLE, CLR. Reset enters CLR (macro defined) or IDLE (macro undefined). In CLR, counter 0..D-1 writes zero to that address in both banks per cycle; at D-1 the FSM moves to IDLE.
REQ-027 While BUSY_OUT=1: WR_EN_IN and SWAP_REQ_IN ignored, RD_DAT_OUT forced to 0, VS_IN has no effect.

Reset
REQ-028 With RST_IN=0 on a rising edge: BANK_OUT=0, SWAP_PEND_OUT=0, RD_DAT_OUT=0 (both pipeline stages), clear counter=0.
REQ-029 BUSY_OUT SHALL be 1 during reset and for exactly D cycles after RST_IN returns to 1 when the macro is defined, and 0 otherwise.
REQ-030 Reset asserted mid-clear SHALL restart the clear from address 0; table contents SHALL NOT otherwise be affected by reset.

Configuration
REQ-031 Macro PRT_SCALER_COEF_CLR_EN: defined -> clear FSM compiled in, both banks zeroed after every reset (REQ-026/029); undefined -> no FSM, BUSY_OUT tied 0, table contents undefined until written.

Verification
REQ-032 Macro defined, defaults; release reset -> BUSY_OUT=1 for exactly 512 cycles; then read all 512 addresses on both ports -> all 0.
REQ-033 Write {mode 3, idx 5}=0xA7 to shadow; read same address -> 0x00; SWAP_REQ_IN pulse, SWAP_PEND_OUT=1; VS_IN pulse -> BANK_OUT=1, SWAP_PEND_OUT=0, read returns 0xA7 two cycles after RD_SEL_IN.
REQ-034 SWAP_REQ_IN and VS_IN in same cycle with SWAP_PEND_OUT=0 -> BANK_OUT toggles next cycle; VS_IN alone with nothing pending -> no toggle.
REQ-035 Port 0 reads addr 0x010 and port 1 reads 0x1FF in the same cycle, values 0x11/0xEE -> both correct at N+2; write to 0x010 in swap cycle -> readable at 0x010 from N+1 sample.
REQ-036 Assert RST_IN=0 at clear cycle 100 for 1 cycle -> BUSY_OUT stays 1 and drops exactly 512 cycles after release; WR_EN_IN pulses during BUSY_OUT leave contents 0.
